csr_regfile_gen2: RTL
=====================

Name: csr_regfile_gen2

Overview:
- Second-generation combined integer register file and machine-mode CSR unit.
- Adds the following:
  - parametrised register count, data width and read-port count;
  - write-first bypass;
  - atomic CSRRW/CSRRS/CSRRC read-modify-write;
  - 64-bit mcycle/minstret counters;
  - hardware trap entry and mret sequencing.
- Sits between decode (read addresses), execute (CSR ops, traps) and writeback (rd write).

Parameters:
- XLEN, 32, data width (32 only for counterh logic; other widths drop the counter high halves).
- REG_NUM, 32, integer registers (16 for RV32E); AW = $clog2(REG_NUM).
- NRD, 2, number of independent integer read ports.
- MTVEC_RST, 32'h0000_0100, reset value of mtvec.
- MVENDORID, 32'h0, read-only vendor ID.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rs_raddr  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rs_rdata  out  NRD*XLEN  packed read data, combinational.
- rd_we  in  1  integer write enable.
- rd_waddr  in  AW  integer write address.
- rd_wdata  in  XLEN  integer write data.
- csr_valid  in  1  CSR instruction executes this cycle.
- csr_op  in  2  01 RW, 10 RS, 11 RC, 00 reserved (no effect, csr_illegal=1).
- csr_addr  in  12  CSR address.
- csr_src  in  XLEN  rs1 value or zero-extended uimm.
- csr_rdata  out  XLEN  old CSR value, combinational.
- csr_illegal  out  1  combinational; unimplemented address, reserved op, or write to read-only.
- instret_inc  in  1  one instruction retired this cycle.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  XLEN  mcause value.
- trap_pc  in  XLEN  faulting PC.
- trap_tval  in  XLEN  mtval value.
- mret  in  1  execute mret this cycle.
- mtvec_o  out  XLEN  current mtvec.
- mepc_o  out  XLEN  current mepc.
- mie_o  out  1  mstatus.MIE.

Behaviour:
- Integer file:
  - x0 always reads 0; writes to x0 are ignored.
  - Writes occur on posedge when rd_we=1.
  - Bypass: if rd_we && rd_waddr==rs_raddr[i] && rd_waddr!=0, rs_rdata[i]=rd_wdata in the same cycle.
  - Registers x1..x(REG_NUM-1) are not reset; x0 reads 0 from cycle 0.
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; other bits read 0.
  - misa 0x301: read-only 0x4000_0100 (RV32I), or 0x4000_0010 if REG_NUM==16.
  - mtvec 0x305: bits[1:0] forced 0 (direct mode).
  - mscratch 0x340: full width writable.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342 and mtval 0x343: full width writable.
  - mcycle 0xB00, minstret 0xB02: writable low halves.
  - mvendorid 0xF11: read-only.
  - Any other address sets csr_illegal=1, csr_rdata=0, no state change.
- CSR write value:
  - RW: src.
  - RS: old|src.
  - RC: old&~src.
  - RS/RC with csr_src==0 performs no write and is legal on read-only CSRs.
  - Any other write to addr[11:10]==2'b11 or misa is illegal.
  - Illegal ops change no state.
- Counters:
  - 64-bit mcycle increments every cycle.
  - 64-bit minstret increments when instret_inc=1.
  - A CSR write to any half of a counter in the same cycle wins: the written half takes csr_src, the other half holds, no increment.
  - Wrap from 2^64-1 to 0 silently.
- Trap entry (trap_valid=1) updates:
  - mepc<=trap_pc&~3.
  - mcause<=trap_cause.
  - mtval<=trap_tval.
  - MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Priority in one cycle, highest first: rst, trap_valid, mret, csr_valid. Lower-priority CSR/mret effects are dropped. Counters and the integer write proceed regardless.
- Reset values:
  - mstatus MIE=0, MPIE=0.
  - mtvec=MTVEC_RST.
  - mscratch=mepc=mcause=mtval=0.
  - counters=0.
- Outputs after reset: mtvec_o=MTVEC_RST, mepc_o=0, mie_o=0.
- Reset asserted mid-operation overrides all same-cycle writes.
- Latency:
  - CSR writes are visible to csr_rdata the next cycle.
  - No CSR bypass: a read in the same cycle returns the old value (read-before-write).

Optional Feature:
- CSR_COUNTERH_EN defined: mcycleh 0xB80 and minstreth 0xB82 are readable and writable as counter bits [63:32].
- Undefined: counters are 32-bit, wrap at 2^32, and 0xB80/0xB82 are illegal.

Test Plan:
- Bypass:
  - Step 1: write x5=0xDEAD_BEEF with rs_raddr port0=5 in the same cycle -> rs_rdata[0]=0xDEAD_BEEF.
  - Step 2: write x0=0x1234 -> x0 reads 0.
- CSR atomic RMW:
  - mscratch RW 0xF0F0 -> csr_rdata=0, next cycle 0xF0F0.
  - RS 0x000F -> reads 0xF0F0, result 0xF0FF.
  - RC 0x00F0 -> result 0xF00F.
- Illegal ops:
  - RW to mvendorid -> csr_illegal=1, value unchanged.
  - RS with src 0 to mvendorid -> csr_illegal=0, returns MVENDORID.
  - Address 0x7C0 -> csr_illegal=1, csr_rdata=0.
- Trap and mret:
  - Start from MIE=1.
  - Trap with pc=0x8000_0047, cause=0xB, tval=0 -> mepc_o=0x8000_0044, mcause=0xB, MIE=0, MPIE=1.
  - mret -> MIE=1.
  - Trap and csr_valid writing mscratch in the same cycle -> mscratch unchanged.
- Counter wrap (CSR_COUNTERH_EN):
  - Write mcycleh=0xFFFF_FFFF, then mcycle=0xFFFF_FFFE.
  - 2 cycles later mcycle=0, mcycleh=0.
  - Without the macro, mcycle wraps at 0xFFFF_FFFF->0 and 0xB80 is illegal.
- Reset mid-operation:
  - Assert rst with trap_valid and rd_we=1 to x3 -> all CSRs at reset values, mtvec_o=0x100.
  - Counters restart from 0 the next cycle.

Source files
------------

// File: rtl/csr_regfile_gen2.sv
// Integer register file with write-first bypass, plus machine-mode CSRs, counters and trap/mret sequencing.
// Optional macro CSR_COUNTERH_EN adds mcycleh/minstreth and widens counters to 64 bits.
module csr_regfile_gen2 #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     REG_NUM   = 32,
   parameter int unsigned     NRD       = 2,
   parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100,
   parameter logic [XLEN-1:0] MVENDORID = 32'h0,
   localparam int unsigned    AW        = $clog2(REG_NUM)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rs_raddr,
   output logic [NRD*XLEN-1:0] rs_rdata,
   input  logic                rd_we,
   input  logic [AW-1:0]       rd_waddr,
   input  logic [XLEN-1:0]     rd_wdata,
   input  logic                csr_valid,
   input  logic [1:0]          csr_op,
   input  logic [11:0]         csr_addr,
   input  logic [XLEN-1:0]     csr_src,
   output logic [XLEN-1:0]     csr_rdata,
   output logic                csr_illegal,
   input  logic                instret_inc,
   input  logic                trap_valid,
   input  logic [XLEN-1:0]     trap_cause,
   input  logic [XLEN-1:0]     trap_pc,
   input  logic [XLEN-1:0]     trap_tval,
   input  logic                mret,
   output logic [XLEN-1:0]     mtvec_o,
   output logic [XLEN-1:0]     mepc_o,
   output logic                mie_o
);

`ifdef CSR_COUNTERH_EN
   localparam bit HAS_H = (XLEN == 32);
`else
   localparam bit HAS_H = 1'b0;
`endif

   localparam int unsigned     CW       = 2 * XLEN;
   localparam logic [XLEN-1:0] MISA_VAL = (REG_NUM == 16) ? XLEN'(32'h4000_0010)
                                                          : XLEN'(32'h4000_0100);

   typedef enum logic [1:0] {
      OP_RSVD = 2'b00,
      OP_RW   = 2'b01,
      OP_RS   = 2'b10,
      OP_RC   = 2'b11
   } csr_op_e;

   // ---------------- integer register file ----------------
   logic [XLEN-1:0] regs_q [REG_NUM];

   // NOTE: the register array is deliberately not reset so it maps onto plain RAM/flop arrays without a reset tree.
   always_ff @(posedge clk) begin
      if (!rst && rd_we && rd_waddr != '0)
         regs_q[rd_waddr] <= rd_wdata;
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rs_raddr[g*AW +: AW];
      assign rs_rdata[g*XLEN +: XLEN] = (ra == '0)                   ? '0       :
                                        (rd_we && rd_waddr == ra)    ? rd_wdata :
                                                                       regs_q[ra];
   end

   // ---------------- CSR state ----------------
   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [XLEN-1:0] mcycle_lo_q, mcycle_lo_d, mcycle_hi_q, mcycle_hi_d;
   logic [XLEN-1:0] minstret_lo_q, minstret_lo_d, minstret_hi_q, minstret_hi_d;

   logic [XLEN-1:0] mstatus_rd, csr_old, csr_wdata;
   logic            addr_ok, is_ro, wants_write, csr_we;
   logic [CW-1:0]   cyc_sum, ins_sum;
   csr_op_e         op;

   assign op = csr_op_e'(csr_op);

   always_comb begin
      mstatus_rd        = '0;
      mstatus_rd[12:11] = 2'b11;
      mstatus_rd[7]     = mpie_q;
      mstatus_rd[3]     = mie_q;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      csr_old = '0;
      addr_ok = 1'b1;
      case (csr_addr)
         12'h300: csr_old = mstatus_rd;
         12'h301: csr_old = MISA_VAL;
         12'h305: csr_old = mtvec_q;
         12'h340: csr_old = mscratch_q;
         12'h341: csr_old = mepc_q;
         12'h342: csr_old = mcause_q;
         12'h343: csr_old = mtval_q;
         12'hB00: csr_old = mcycle_lo_q;
         12'hB02: csr_old = minstret_lo_q;
         12'hB80: begin
            addr_ok = HAS_H;
            csr_old = HAS_H ? mcycle_hi_q : '0;
         end
         12'hB82: begin
            addr_ok = HAS_H;
            csr_old = HAS_H ? minstret_hi_q : '0;
         end
         12'hF11: csr_old = MVENDORID;
         default: addr_ok = 1'b0;
      endcase
   end

   assign csr_rdata = csr_old;

   always_comb begin
      csr_wdata = csr_src;
      case (op)
         OP_RS:   csr_wdata = csr_old | csr_src;
         OP_RC:   csr_wdata = csr_old & ~csr_src;
         default: csr_wdata = csr_src;
      endcase
   end

   // Set/clear with a zero mask is a pure read, which stays legal on read-only CSRs.
   assign is_ro       = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h301);
   assign wants_write = (op == OP_RW) || ((op == OP_RS || op == OP_RC) && csr_src != '0);
   assign csr_illegal = csr_valid && (!addr_ok || op == OP_RSVD || (wants_write && is_ro));
   assign csr_we      = csr_valid && !csr_illegal && wants_write && !trap_valid && !mret;

   assign cyc_sum = {mcycle_hi_q, mcycle_lo_q} + CW'(1);
   assign ins_sum = {minstret_hi_q, minstret_lo_q} + CW'(instret_inc);

   always_comb begin
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      mtvec_d       = mtvec_q;
      mscratch_d    = mscratch_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      mcycle_lo_d   = cyc_sum[XLEN-1:0];
      mcycle_hi_d   = HAS_H ? cyc_sum[CW-1:XLEN] : '0;
      minstret_lo_d = ins_sum[XLEN-1:0];
      minstret_hi_d = HAS_H ? ins_sum[CW-1:XLEN] : '0;

      if (trap_valid) begin
         mepc_d   = trap_pc & ~XLEN'(3);
         mcause_d = trap_cause;
         mtval_d  = trap_tval;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (csr_we) begin
         case (csr_addr)
            12'h300: begin
               mie_d  = csr_wdata[3];
               mpie_d = csr_wdata[7];
            end
            12'h305: mtvec_d    = csr_wdata & ~XLEN'(3);
            12'h340: mscratch_d = csr_wdata;
            12'h341: mepc_d     = csr_wdata & ~XLEN'(3);
            12'h342: mcause_d   = csr_wdata;
            12'h343: mtval_d    = csr_wdata;
            // A counter write freezes the other half and suppresses the increment.
            12'hB00: begin
               mcycle_lo_d = csr_wdata;
               mcycle_hi_d = mcycle_hi_q;
            end
            12'hB02: begin
               minstret_lo_d = csr_wdata;
               minstret_hi_d = minstret_hi_q;
            end
            12'hB80: begin
               mcycle_hi_d = csr_wdata;
               mcycle_lo_d = mcycle_lo_q;
            end
            12'hB82: begin
               minstret_hi_d = csr_wdata;
               minstret_lo_d = minstret_lo_q;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample their _d values from the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         mtvec_q       <= MTVEC_RST;
         mscratch_q    <= '0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         mtval_q       <= '0;
         mcycle_lo_q   <= '0;
         mcycle_hi_q   <= '0;
         minstret_lo_q <= '0;
         minstret_hi_q <= '0;
      end else begin
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         mcycle_lo_q   <= mcycle_lo_d;
         mcycle_hi_q   <= mcycle_hi_d;
         minstret_lo_q <= minstret_lo_d;
         minstret_hi_q <= minstret_hi_d;
      end
   end

   assign mtvec_o = mtvec_q;
   assign mepc_o  = mepc_q;
   assign mie_o   = mie_q;

endmodule
